// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the MIPS fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] LINK_OFFSET      = 32'd8;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + LINK_OFFSET;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Priority mux choosing the next fetch PC from exceptions, stalls and ID redirects.
module next_pc_sel
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [31:0] pc_f,
    input  logic        flush_excp,
    input  logic [31:0] excp_pc,
    input  logic        stall_f,
    input  logic        jr_d,
    input  logic [31:0] jr_target_d,
    input  logic        jump_d,
    input  logic [31:0] jump_target_d,
    input  logic        pcsrc_d,
    input  logic [31:0] branch_target_d,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_f + PC_STEP;
        // Exception redirect must win over a stall so eret/exceptions are never lost.
        if (flush_excp) begin
            next_pc = excp_pc;
        end else if (stall_f) begin
            next_pc = pc_f;
        end else if (jr_d) begin
            next_pc = jr_target_d;
        end else if (jump_d) begin
            next_pc = jump_target_d;
        end else if (pcsrc_d) begin
            next_pc = branch_target_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register, instruction-SRAM request, IF/ID register and stall hold buffer.
// Optional misaligned-fetch (AdEL) detection is enabled by defining FETCH_ADEL_CHECK_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        flush_excp,
    input  logic [31:0] excp_pc,
    input  logic        is_bj_d,
    input  logic        pcsrc_d,
    input  logic [31:0] branch_target_d,
    input  logic        jump_d,
    input  logic [31:0] jump_target_d,
    input  logic        jr_d,
    input  logic [31:0] jr_target_d,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic        delay_slot_d,
    output logic        adel_d
);

    logic [31:0] next_pc;
    logic        misaligned;
    logic        flush_any;
    logic        capture;
    logic [31:0] hold_buf;
    hold_state_e state_q, state_d;

    next_pc_sel #(
        .PC_STEP(PC_STEP)
    ) u_next_pc_sel (
        .pc_f           (pc_f),
        .flush_excp     (flush_excp),
        .excp_pc        (excp_pc),
        .stall_f        (stall_f),
        .jr_d           (jr_d),
        .jr_target_d    (jr_target_d),
        .jump_d         (jump_d),
        .jump_target_d  (jump_target_d),
        .pcsrc_d        (pcsrc_d),
        .branch_target_d(branch_target_d),
        .next_pc        (next_pc)
    );

`ifdef FETCH_ADEL_CHECK_EN
    assign misaligned = (pc_f[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign inst_sram_en   = ~rst & ~stall_f & ~misaligned;
    assign inst_sram_addr = pc_f;

    // A stalled flush_d is ignored; the hazard unit never pairs the two.
    assign flush_any = flush_excp | (flush_d & ~stall_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_d         <= 32'h0;
            pc_plus8_d   <= LINK_OFFSET;
            valid_d      <= 1'b0;
            delay_slot_d <= 1'b0;
        end else if (flush_any) begin
            valid_d      <= 1'b0;
            delay_slot_d <= 1'b0;
        end else if (stall_d) begin
            valid_d      <= valid_d;
        end else if (stall_f) begin
            valid_d      <= 1'b0;
            delay_slot_d <= 1'b0;
        end else begin
            pc_d         <= pc_f;
            pc_plus8_d   <= link_addr(pc_f);
            valid_d      <= 1'b1;
            delay_slot_d <= is_bj_d & valid_d;
        end
    end

`ifdef FETCH_ADEL_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk) begin
        if (rst || flush_any) begin
            adel_q <= 1'b0;
        end else if (!stall_d) begin
            adel_q <= stall_f ? 1'b0 : misaligned;
        end
    end

    assign adel_d = adel_q;
`else
    assign adel_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (flush_any) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall_d) begin
                        state_d = HOLD;
                        capture = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_d) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            hold_buf <= NOP;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_buf <= inst_sram_rdata;
            end else if (flush_any) begin
                hold_buf <= NOP;
            end
        end
    end

    // SRAM data only reflects the ID instruction for one cycle; the buffer covers stalls.
    always_comb begin
        instr_d = inst_sram_rdata;
        if (!valid_d || adel_d) begin
            instr_d = NOP;
        end else if (state_q == HOLD) begin
            instr_d = hold_buf;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a one-cycle-latency SRAM model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, flush_excp;
    logic [31:0] excp_pc;
    logic        is_bj_d, pcsrc_d, jump_d, jr_d;
    logic [31:0] branch_target_d, jump_target_d, jr_target_d;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr, inst_sram_rdata;
    logic [31:0] pc_f, pc_d, pc_plus8_d, instr_d;
    logic        valid_d, delay_slot_d, adel_d;

    logic [31:0] rdata_q = 32'h0;
    logic        rdata_ovr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC0_0018) return 32'h8C22_0004;
        return {16'hA000, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (inst_sram_en) rdata_q <= mem(inst_sram_addr);
    end

    assign inst_sram_rdata = rdata_ovr ? 32'hDEAD_BEEF : rdata_q;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_excp     (flush_excp),
        .excp_pc        (excp_pc),
        .is_bj_d        (is_bj_d),
        .pcsrc_d        (pcsrc_d),
        .branch_target_d(branch_target_d),
        .jump_d         (jump_d),
        .jump_target_d  (jump_target_d),
        .jr_d           (jr_d),
        .jr_target_d    (jr_target_d),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .pc_f           (pc_f),
        .pc_d           (pc_d),
        .pc_plus8_d     (pc_plus8_d),
        .instr_d        (instr_d),
        .valid_d        (valid_d),
        .delay_slot_d   (delay_slot_d),
        .adel_d         (adel_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        is_bj_d = 0; pcsrc_d = 0; jump_d = 0; jr_d = 0;
    endtask

    initial begin
        rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; flush_excp = 0;
        excp_pc = 0; branch_target_d = 0; jump_target_d = 0; jr_target_d = 0;
        clear_redirects();
        step();
        step();
        check("rst_en", {31'h0, inst_sram_en}, 32'h0);
        rst = 0;
        #1;
        // Reset state, first fetch.
        check("rst_pc_f", pc_f, 32'hBFC0_0000);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_pc8", pc_plus8_d, 32'h8);
        check("rst_valid", {31'h0, valid_d}, 32'h0);
        check("rst_instr", instr_d, 32'h0);
        check("rst_ds", {31'h0, delay_slot_d}, 32'h0);
        check("rst_adel", {31'h0, adel_d}, 32'h0);
        check("addr0", inst_sram_addr, 32'hBFC0_0000);
        check("en0", {31'h0, inst_sram_en}, 32'h1);

        step();
        check("addr1", inst_sram_addr, 32'hBFC0_0004);
        check("valid1", {31'h0, valid_d}, 32'h1);
        check("pc_d1", pc_d, 32'hBFC0_0000);
        check("pc8_1", pc_plus8_d, 32'hBFC0_0008);
        check("instr1", instr_d, mem(32'hBFC0_0000));
        step();
        check("addr2", inst_sram_addr, 32'hBFC0_0008);
        step();
        step();
        step();
        check("br_pre_pc_d", pc_d, 32'hBFC0_0010);
        check("br_pre_pc_f", pc_f, 32'hBFC0_0014);

        // Taken branch in ID at BFC00010.
        is_bj_d = 1; pcsrc_d = 1; branch_target_d = 32'hBFC0_0100;
        step();
        clear_redirects();
        check("br_ds_pc", pc_d, 32'hBFC0_0014);
        check("br_ds_flag", {31'h0, delay_slot_d}, 32'h1);
        check("br_tgt_pc_f", pc_f, 32'hBFC0_0100);
        step();
        check("br_tgt_pc_d", pc_d, 32'hBFC0_0100);
        check("br_tgt_ds", {31'h0, delay_slot_d}, 32'h0);

        // Jump back to BFC00010, then not-taken branch there.
        is_bj_d = 1; jump_d = 1; jump_target_d = 32'hBFC0_0010;
        step();
        clear_redirects();
        check("j_pc_f", pc_f, 32'hBFC0_0010);
        check("j_ds", {31'h0, delay_slot_d}, 32'h1);
        step();
        check("nt_pre_pc_d", pc_d, 32'hBFC0_0010);
        is_bj_d = 1; pcsrc_d = 0;
        step();
        clear_redirects();
        check("nt_ds_pc", pc_d, 32'hBFC0_0014);
        check("nt_ds_flag", {31'h0, delay_slot_d}, 32'h1);
        check("nt_pc_f", pc_f, 32'hBFC0_0018);
        step();
        check("nt_next_pc_d", pc_d, 32'hBFC0_0018);
        check("nt_next_ds", {31'h0, delay_slot_d}, 32'h0);
        check("ld_instr", instr_d, 32'h8C22_0004);

        // Three-cycle stall; SRAM output is corrupted after the first stall edge.
        stall_f = 1; stall_d = 1;
        #1;
        check("st0_instr", instr_d, 32'h8C22_0004);
        check("st0_en", {31'h0, inst_sram_en}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            rdata_ovr = 1;
            #1;
            check($sformatf("st%0d_instr", i + 1), instr_d, 32'h8C22_0004);
            check($sformatf("st%0d_pc_f", i + 1), pc_f, 32'hBFC0_001C);
            check($sformatf("st%0d_pc_d", i + 1), pc_d, 32'hBFC0_0018);
        end
        stall_f = 0; stall_d = 0; rdata_ovr = 0;
        #1;
        check("rel_instr", instr_d, 32'h8C22_0004);
        step();
        check("rel_pc_d", pc_d, 32'hBFC0_001C);
        check("rel_instr_next", instr_d, mem(32'hBFC0_001C));
        check("rel_valid", {31'h0, valid_d}, 32'h1);

        // Exception redirect while stalled.
        stall_f = 1; stall_d = 1; flush_excp = 1; excp_pc = 32'hBFC0_0380;
        step();
        stall_f = 0; stall_d = 0; flush_excp = 0;
        check("ex_pc_f", pc_f, 32'hBFC0_0380);
        check("ex_valid", {31'h0, valid_d}, 32'h0);
        check("ex_instr", instr_d, 32'h0);
        step();
        check("ex_pc_f2", pc_f, 32'hBFC0_0384);
        check("ex_pc_d", pc_d, 32'hBFC0_0380);
        check("ex_instr2", instr_d, mem(32'hBFC0_0380));

        // jr beats a taken branch.
        is_bj_d = 1; jr_d = 1; jr_target_d = 32'hBFC0_0200;
        pcsrc_d = 1; branch_target_d = 32'hBFC0_0300;
        step();
        clear_redirects();
        check("jr_pc_f", pc_f, 32'hBFC0_0200);
        step();
        check("jr_pc_d", pc_d, 32'hBFC0_0200);

        // flush_d alone gives one bubble.
        flush_d = 1;
        step();
        flush_d = 0;
        check("fl_valid", {31'h0, valid_d}, 32'h0);
        check("fl_instr", instr_d, 32'h0);
        step();
        check("fl_valid2", {31'h0, valid_d}, 32'h1);
        check("fl_pc_d", pc_d, 32'hBFC0_0208);

        // Misaligned jr target.
        is_bj_d = 1; jr_d = 1; jr_target_d = 32'hBFC0_0102;
        step();
        clear_redirects();
        check("ad_pc_f", pc_f, 32'hBFC0_0102);
`ifdef FETCH_ADEL_CHECK_EN
        check("ad_en", {31'h0, inst_sram_en}, 32'h0);
`else
        check("ad_en", {31'h0, inst_sram_en}, 32'h1);
`endif
        step();
        check("ad_pc_d", pc_d, 32'hBFC0_0102);
        check("ad_valid", {31'h0, valid_d}, 32'h1);
`ifdef FETCH_ADEL_CHECK_EN
        check("ad_adel", {31'h0, adel_d}, 32'h1);
        check("ad_instr", instr_d, 32'h0);
`else
        check("ad_adel", {31'h0, adel_d}, 32'h0);
        check("ad_instr", instr_d, mem(32'hBFC0_0102));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
